// File: rtl/candle_selector.sv
// ---------------------------------------------------------------------------
// candle_selector
//
// Operator-input front end for the candle extinguisher stage. Three raw
// push-buttons are synchronized and debounced; left/right step a 3-bit candle
// cursor and centre fires a held enable window that is long enough for the
// extinguisher's free-running 3-bit counter to match the cursor.
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a synchronized level must hold to be accepted
//                    (2..65535)
//   ENABLE_HOLD      cycles enable stays high per fire (>= 8)
//   REPEAT_CYCLES    auto-repeat interval (auto-repeat build only)
//
// Build option:
//   CANDLE_SELECTOR_AUTO_REPEAT_EN  when defined, holding exactly one of
//                                   left/right in IDLE keeps stepping the
//                                   cursor every REPEAT_CYCLES cycles.
//
// Ports:
//   sys_clk     in   system clock
//   clr_n       in   asynchronous active-low reset
//   btn_left    in   raw button, decrements cursor
//   btn_right   in   raw button, increments cursor
//   btn_center  in   raw button, fires the extinguish window
//   position    out  current cursor 0..7
//   enable      out  extinguish window to the downstream stage
//   busy        out  high while firing or waiting for centre release
// ---------------------------------------------------------------------------
module candle_selector #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned ENABLE_HOLD     = 8,
    parameter int unsigned REPEAT_CYCLES   = 64
) (
    input  logic       sys_clk,
    input  logic       clr_n,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_center,
    output logic [2:0] position,
    output logic       enable,
    output logic       busy
);

    // Button lane indices shared by the synchronizer/debouncer vectors.
    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_C = 2;

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    localparam int              HOLD_W    = $clog2(ENABLE_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ENABLE_HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_FIRE         = 2'd1,
        ST_WAIT_RELEASE = 2'd2
    } state_t;

    logic [2:0]  raw;
    logic [2:0]  sync1;
    logic [2:0]  sync2;
    logic [2:0]  stable;
    logic [2:0]  press;
    logic [15:0] db_cnt [3];

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;

    logic rep_up;
    logic rep_dn;
    logic step_up;
    logic step_dn;

    assign raw = {btn_center, btn_right, btn_left};

    // -----------------------------------------------------------------------
    // Input path: 2-flop synchronizer, then a per-lane debouncer. The counter
    // only runs while the synchronized level disagrees with the accepted one,
    // so any disagreement shorter than DEBOUNCE_CYCLES is discarded. A press
    // is flagged for one cycle in the cycle after a rising acceptance.
    // -----------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge clr_n) begin
        if (!clr_n) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            press  <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                    press[i]  <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                end
            end
        end
    end

`ifdef CANDLE_SELECTOR_AUTO_REPEAT_EN
    // -----------------------------------------------------------------------
    // Auto-repeat. Each direction has its own counter that runs only in IDLE
    // while that direction alone is held. The press cycle sees the counter at
    // 0, so a step fires when it reaches REPEAT_CYCLES (REPEAT_CYCLES cycles
    // after the press), after which it restarts at 1 to keep the same period.
    // -----------------------------------------------------------------------
    localparam int               REP_W    = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES);

    logic [REP_W-1:0] rep_cnt_up;
    logic [REP_W-1:0] rep_cnt_dn;
    logic             run_up;
    logic             run_dn;

    assign run_up = (state == ST_IDLE) && stable[BTN_R] && !stable[BTN_L];
    assign run_dn = (state == ST_IDLE) && stable[BTN_L] && !stable[BTN_R];
    assign rep_up = run_up && (rep_cnt_up == REP_LAST);
    assign rep_dn = run_dn && (rep_cnt_dn == REP_LAST);

    always_ff @(posedge sys_clk or negedge clr_n) begin
        if (!clr_n) begin
            rep_cnt_up <= '0;
            rep_cnt_dn <= '0;
        end else begin
            if (!run_up) begin
                rep_cnt_up <= '0;
            end else if (rep_up) begin
                rep_cnt_up <= REP_W'(1);
            end else begin
                rep_cnt_up <= rep_cnt_up + REP_W'(1);
            end

            if (!run_dn) begin
                rep_cnt_dn <= '0;
            end else if (rep_dn) begin
                rep_cnt_dn <= REP_W'(1);
            end else begin
                rep_cnt_dn <= rep_cnt_dn + REP_W'(1);
            end
        end
    end
`else
    // Without auto-repeat a press gives exactly one step; the debounced
    // left/right levels and the repeat interval have no consumer here.
    logic unused_levels;

    assign rep_up        = 1'b0;
    assign rep_dn        = 1'b0;
    assign unused_levels = ^{stable[BTN_L], stable[BTN_R], 32'(REPEAT_CYCLES)};
`endif

    assign step_up = press[BTN_R] | rep_up;
    assign step_dn = press[BTN_L] | rep_dn;

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs. The cursor only moves in IDLE; a
    // centre press wins over a simultaneous step so the extinguisher sees the
    // pre-fire cursor. enable is set on entry to FIRE and cleared on the last
    // hold count, giving exactly ENABLE_HOLD cycles high.
    // -----------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= ST_IDLE;
            position <= 3'd0;
            enable   <= 1'b0;
            busy     <= 1'b0;
            hold_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (press[BTN_C]) begin
                        state    <= ST_FIRE;
                        enable   <= 1'b1;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                    end else if (step_up && !step_dn) begin
                        position <= position + 3'd1;
                    end else if (step_dn && !step_up) begin
                        position <= position - 3'd1;
                    end
                end

                ST_FIRE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state  <= ST_WAIT_RELEASE;
                        enable <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end

                ST_WAIT_RELEASE: begin
                    // Leave as soon as the debounced centre level is low,
                    // which may already be true on the first cycle here.
                    if (!stable[BTN_C]) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    enable <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/candle_selector.md
Name: candle_selector

Overview:
- Operator-input front end for the candle extinguisher stage.
- Synchronizes and debounces three push-buttons: left, right, centre.
- Left/right step a 3-bit candle cursor; centre fires a held enable window.
- Drives the extinguisher's position and enable inputs directly. The window is long enough that the extinguisher's free-running 3-bit counter is guaranteed to match the cursor.

Parameters:
- DEBOUNCE_CYCLES, default 16: consecutive sys_clk cycles a synchronized level must hold before it is accepted; legal range 2..65535.
- ENABLE_HOLD, default 8: cycles enable stays high per fire; minimum 8, one full extinguisher counter period.
- REPEAT_CYCLES, default 64: auto-repeat interval; used only with AUTO_REPEAT_EN.

Ports:
- sys_clk  input  1  system clock
- clr_n  input  1  asynchronous active-low reset
- btn_left  input  1  raw asynchronous button; decrements cursor
- btn_right  input  1  raw asynchronous button; increments cursor
- btn_center  input  1  raw asynchronous button; fires extinguish window
- position  output  3  current cursor, 0..7
- enable  output  1  extinguish window to downstream stage
- busy  output  1  high in FIRE or WAIT_RELEASE

Behaviour:
- Reset and clocking:
  - One clock, sys_clk.
  - Reset clr_n is asynchronous and active-low; it clears all state immediately, with no clock needed.
  - Reset values: position=0, enable=0, busy=0, FSM=IDLE, all synchronizer flops, debounce counters and stable levels = 0.
- Per-button input path:
  - 2-flop synchronizer.
  - Debouncer:
    - Counter clears whenever the synchronized level equals the stable level.
    - Otherwise the counter increments.
    - When the counter reaches DEBOUNCE_CYCLES-1, the stable level takes the synchronized level and the counter clears.
  - A press pulse is one cycle, on the rising edge of the stable level. Releases produce no pulse.
- Latency:
  - A raw level held constant from edge N is accepted at stable level on edge N+2+DEBOUNCE_CYCLES.
  - The resulting position/enable change is visible after edge N+3+DEBOUNCE_CYCLES.
- Cursor rules (IDLE only):
  - right pulse: position+1 mod 8, so 7 wraps to 0.
  - left pulse: position-1 mod 8, so 0 wraps to 7.
  - left and right pulses in the same cycle: no change.
- FSM states: IDLE, FIRE, WAIT_RELEASE.
  - IDLE: a centre pulse goes to FIRE. Any left/right pulse in that same cycle is ignored, so the cursor is frozen at its pre-fire value.
  - FIRE:
    - enable=1 and busy=1.
    - Hold counter counts 0..ENABLE_HOLD-1; on the last count, go to WAIT_RELEASE.
    - enable is high for exactly ENABLE_HOLD cycles.
    - Left/right/centre pulses are ignored and position stays constant.
  - WAIT_RELEASE:
    - enable=0, busy=1.
    - Return to IDLE on the first cycle the debounced centre level is 0. This may be the first cycle of WAIT_RELEASE.
    - Left/right pulses are ignored.
- Mid-operation reset: asserting clr_n low during FIRE drops enable to 0 asynchronously. After reset, the FSM is IDLE and position is 0.
- A glitch shorter than DEBOUNCE_CYCLES never changes the stable level.

Optional Feature:
- Macro: CANDLE_SELECTOR_AUTO_REPEAT_EN
- Defined:
  - In IDLE, while exactly one of debounced left/right is held, a per-direction repeat counter runs.
  - The first repeat step occurs REPEAT_CYCLES cycles after the press pulse, then every REPEAT_CYCLES cycles.
  - Each step applies the same wrap rules as a press.
  - The counter clears on release, when both buttons are held, and outside IDLE.
- Undefined: repeat logic is absent; one press gives exactly one step.

Test Plan (DEBOUNCE_CYCLES=4, ENABLE_HOLD=8, REPEAT_CYCLES=16):
- After reset, press right 3 times, each press held 10 cycles with 10 cycles between -> position 0,1,2,3; each step lands 7 edges after the raw rise.
- From position 0, press left once -> position 7. Then press right -> position 0.
- Position 5, hold centre 20 cycles:
  - enable high exactly 8 consecutive cycles starting 7 edges after the raw rise.
  - busy stays high until the debounced release.
  - position stays 5 throughout.
- 3-cycle pulse on btn_right, then bounce pattern 1,0,1,0 at one cycle each -> position unchanged, no enable.
- Left and right raw-rise on the same edge, held 10 cycles -> position unchanged. A right pulse during FIRE -> position unchanged after return to IDLE.
- clr_n low during the 4th cycle of FIRE -> enable=0, busy=0, position=0 immediately. A new centre press afterwards gives a full 8-cycle window.
